counter_mod: RTL and testbench



---
 rtl/counter_mod.sv | 41 ++++
 tb/tb_counter_mod.sv | 136 +++++++++++++
 2 files changed

// File: rtl/counter_mod.sv
// Enable-gated modulo event counter: pulses op_done for one cycle after every
// TERMINAL enabled clock cycles, pausing (without losing progress) while countEN is low.
module counter_mod #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic countEN,
    output logic op_done
);

    // Last count value of an operation; with TERMINAL == 2**WIDTH this is all-ones,
    // so the explicit wrap coincides with natural overflow.
    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_op_done;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LP_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_op_done <= 1'b0;
        end else begin
            r_op_done <= countEN && w_at_last;
            if (countEN) begin
                if (w_at_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign op_done = r_op_done;

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: three instances (TERMINAL 5, TERMINAL 1, and
// WIDTH 3 / TERMINAL 8) checked against a behavioural model through a scoreboard queue.
module tb_counter_mod;

    typedef struct {
        int    dut;
        bit    exp;
        string tag;
    } sb_item_t;

    logic       clock;
    logic [2:0] rst_n;
    logic [2:0] en;
    logic [2:0] done;

    int         vectors;
    int         miscompares;
    int         m_cnt [3];
    int         m_term[3];
    sb_item_t   sb_q[$];

    counter_mod #(.WIDTH(8), .TERMINAL(5)) u_t5 (
        .clock(clock), .reset(rst_n[0]), .countEN(en[0]), .op_done(done[0])
    );
    counter_mod #(.WIDTH(8), .TERMINAL(1)) u_t1 (
        .clock(clock), .reset(rst_n[1]), .countEN(en[1]), .op_done(done[1])
    );
    counter_mod #(.WIDTH(3), .TERMINAL(8)) u_w3 (
        .clock(clock), .reset(rst_n[2]), .countEN(en[2]), .op_done(done[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_pop();
        sb_item_t it;
        logic     obs;
        it  = sb_q.pop_front();
        obs = done[it.dut];
        vectors++;
        assert (obs === it.exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%0b expected=%0b", it.tag, it.dut, obs, it.exp);
        end
    endtask

    // Drive one cycle on instance d (others idle), predict, clock, compare.
    task automatic step(input int d, input bit e, input string tag);
        sb_item_t it;
        en     = '0;
        en[d]  = e;
        it.dut = d;
        it.tag = tag;
        if (rst_n[d] !== 1'b1) begin
            it.exp   = 1'b0;
            m_cnt[d] = 0;
        end else begin
            it.exp = e && (m_cnt[d] == m_term[d] - 1);
            if (e) m_cnt[d] = (m_cnt[d] == m_term[d] - 1) ? 0 : m_cnt[d] + 1;
        end
        sb_q.push_back(it);
        @(posedge clock);
        #1;
        check_pop();
    endtask

    // Asynchronous reset pulse between edges; op_done must clear at once.
    task automatic async_reset(input int d, input string tag);
        sb_item_t it;
        #2;
        rst_n[d] = 1'b0;
        it.dut   = d;
        it.exp   = 1'b0;
        it.tag   = tag;
        sb_q.push_back(it);
        #1;
        check_pop();
        m_cnt[d] = 0;
        #1;
        rst_n[d] = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_term[0] = 5; m_term[1] = 1; m_term[2] = 8;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        rst_n = '0;
        en    = '1;

        // Reset held with enable high: no progress, no pulse.
        for (int i = 0; i < 3; i++) step(0, 1'b1, "reset_hold");
        #1;
        rst_n = '1;

        // First operation after reset: pulse only after 5th enabled edge.
        for (int i = 0; i < 5; i++) step(0, 1'b1, "first_op");
        step(0, 1'b0, "first_op_drop");

        // Paused operation.
        for (int i = 0; i < 4; i++) step(0, 1'b1, "pause_pre");
        for (int i = 0; i < 2; i++) step(0, 1'b0, "pause_hold");
        step(0, 1'b1, "pause_done");
        step(0, 1'b1, "pause_drop");

        // Realign to a fresh operation, then 15 continuous edges.
        for (int i = 0; i < 4; i++) step(0, 1'b1, "realign");
        for (int i = 0; i < 15; i++) step(0, 1'b1, "continuous");

        // Reset mid-operation discards progress.
        for (int i = 0; i < 3; i++) step(0, 1'b1, "mid_pre");
        async_reset(0, "mid_async");
        for (int i = 0; i < 4; i++) step(0, 1'b1, "mid_post");
        step(0, 1'b1, "mid_done");

        // Reset while a pulse is in flight clears it asynchronously.
        for (int i = 0; i < 5; i++) step(0, 1'b1, "inflight_pre");
        async_reset(0, "inflight_clear");
        step(0, 1'b1, "inflight_post");

        // TERMINAL = 1.
        step(1, 1'b1, "t1_a");
        step(1, 1'b1, "t1_b");
        step(1, 1'b0, "t1_c");
        step(1, 1'b1, "t1_d");
        step(1, 1'b0, "t1_e");

        // Full-width wrap: WIDTH 3, TERMINAL 8.
        for (int i = 0; i < 16; i++) step(2, 1'b1, "wrap_full");
        step(2, 1'b0, "wrap_drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
